// File: rtl/tmip_out_collect_if.sv
// Word-side handshake bundle for tmip_out_collect: FIFO head valid/data and consumer ready.
// Master drives word_valid/word_data; slave drives word_ready.
// Pop happens on any cycle where word_valid & word_ready.
interface tmip_out_collect_if #(
  parameter int WORD_W = 20
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/tmip_out_collect.sv
// Purpose: deserialize TMIP's 1-bit out_value stream into WORD_W-bit words (MSB first), buffer them in a FIFO, report frame counts/errors.
// Latency: word_valid rises the cycle after the edge sampling a word's last bit; frame_done pulses the cycle after frame end.
// Backpressure: word_ready holds the FIFO head; a word completing into a full FIFO with no same-cycle pop is dropped (err_overflow).
// Optional feature macro TMIP_COLLECT_SUM_EN adds the frame_sum port and its per-frame word adder.
module tmip_out_collect #(
  parameter int WORD_W = 20,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  out_valid,
  input  logic                  out_value,
  tmip_out_collect_if.master    wbus,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_words,
  output logic                  err_partial,
  output logic                  err_overflow,
  input  logic                  clr_err
`ifdef TMIP_COLLECT_SUM_EN
  ,
  output logic [31:0]           frame_sum
`endif
);

  localparam int BC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state, state_nxt;
  logic              frame_end;
  logic [WORD_W-2:0] sreg;        // first WORD_W-1 bits of the word in flight
  logic [BC_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]  frame_cnt;
  logic [WORD_W-1:0] word_asm;
  logic              word_done;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic              push, pop, ovf_set;

  // The completing word is the shifted history plus the bit sampled this cycle.
  assign word_asm  = {sreg, out_value};
  assign word_done = out_valid && (bit_cnt == LAST_BIT);

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = wbus.word_valid && wbus.word_ready;
  assign push       = word_done && (!fifo_full || pop);
  assign ovf_set    = word_done && fifo_full && !pop;

  assign wbus.word_valid = !fifo_empty;
  assign wbus.word_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; frame end is the first out_valid=0 sample while receiving.
  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE: if (out_valid) state_nxt = RECV;
      RECV: if (!out_valid) begin
        state_nxt = IDLE;
        frame_end = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and saturating per-frame word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (out_valid) begin
        sreg    <= word_asm[WORD_W-2:0];
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end else if (frame_end) begin
        bit_cnt <= '0;
      end
      if (frame_end)
        frame_cnt <= '0;
      else if (word_done && (frame_cnt != '1))
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Frame-end reporting and sticky errors; a same-cycle set beats clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done   <= 1'b0;
      frame_words  <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      frame_done   <= frame_end;
      if (frame_end) frame_words <= frame_cnt;
      err_partial  <= (frame_end && (bit_cnt != '0)) || (err_partial && !clr_err);
      err_overflow <= ovf_set || (err_overflow && !clr_err);
    end
  end

  // FIFO pointers; reset flushes everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are masked by fifo_empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= word_asm;
  end

`ifdef TMIP_COLLECT_SUM_EN
  logic [31:0] sum_acc;

  // Running sum of every completed word (dropped ones too), published at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (frame_end) begin
      sum_acc   <= '0;
      frame_sum <= sum_acc;
    end else if (word_done) begin
      sum_acc   <= sum_acc + 32'(word_asm);
    end
  end
`endif

endmodule

// File: tb/tb_tmip_out_collect.sv
// Self-checking bench for tmip_out_collect: directed scenarios plus randomized frames
// checked against a word-level model (word lists, FIFO capacity, frame totals).
module tb_tmip_out_collect;
  localparam int WORD_W = 20;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_valid = 1'b0;
  logic out_value = 1'b0;
  logic clr_err = 1'b0;
  logic frame_done;
  logic [CNT_W-1:0] frame_words;
  logic err_partial;
  logic err_overflow;
`ifdef TMIP_COLLECT_SUM_EN
  logic [31:0] frame_sum;
`endif

  tmip_out_collect_if #(.WORD_W(WORD_W)) wif ();

  tmip_out_collect #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .out_valid    (out_valid),
    .out_value    (out_value),
    .wbus         (wif),
    .frame_done   (frame_done),
    .frame_words  (frame_words),
    .err_partial  (err_partial),
    .err_overflow (err_overflow),
    .clr_err      (clr_err)
`ifdef TMIP_COLLECT_SUM_EN
    ,
    .frame_sum    (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit rand_ready = 1'b0;
  logic [WORD_W-1:0] got_q[$];

  // Consumer side: record every accepted word and every frame_done pulse.
  always @(negedge clk) begin
    if (rst_n && wif.word_valid && wif.word_ready) got_q.push_back(wif.word_data);
    if (rst_n && frame_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send nb bits of w, MSB side first, starting from_msb bits below the MSB.
  task automatic send_bits(input logic [WORD_W-1:0] w, input int from_msb, input int nb);
    for (int i = 0; i < nb; i++) begin
      out_valid = 1'b1;
      out_value = w[WORD_W-1-from_msb-i];
      if (rand_ready) wif.word_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    send_bits(w, 0, WORD_W);
  endtask

  task automatic end_frame();
    out_valid = 1'b0;
    out_value = 1'b0;
    tick();
  endtask

  task automatic drain();
    wif.word_ready = 1'b1;
    repeat (DEPTH + 4) tick();
  endtask

  task automatic test_reset();
    n_vec++; if (wif.word_valid !== 1'b0) begin n_err++; $display("FAIL reset_word_valid: got %b expected 0", wif.word_valid); end
    n_vec++; if (wif.word_data !== '0) begin n_err++; $display("FAIL reset_word_data: got %h expected 0", wif.word_data); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_vec++; if (frame_words !== '0) begin n_err++; $display("FAIL reset_frame_words: got %0d expected 0", frame_words); end
    n_vec++; if ({err_partial, err_overflow} !== 2'b00) begin n_err++; $display("FAIL reset_errors: got %b%b expected 00", err_partial, err_overflow); end
`ifdef TMIP_COLLECT_SUM_EN
    n_vec++; if (frame_sum !== 32'd0) begin n_err++; $display("FAIL reset_frame_sum: got %0d expected 0", frame_sum); end
`endif
  endtask

  task automatic test_frame_4x4();
    got_q.delete(); done_cnt = 0; wif.word_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_word(WORD_W'(i));
    end_frame();
    n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL 4x4_frame_done: got %b expected 1", frame_done); end
    n_vec++; if (frame_words !== CNT_W'(16)) begin n_err++; $display("FAIL 4x4_frame_words: got %0d expected 16", frame_words); end
`ifdef TMIP_COLLECT_SUM_EN
    n_vec++; if (frame_sum !== 32'd120) begin n_err++; $display("FAIL 4x4_frame_sum: got %0d expected 120", frame_sum); end
`endif
    drain();
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL 4x4_done_pulses: got %0d expected 1", done_cnt); end
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL 4x4_word_count: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== WORD_W'(i)) begin n_err++; $display("FAIL 4x4_word[%0d]: got %h expected %h", i, got_q[i], i); end
    end
    n_vec++; if ({err_partial, err_overflow} !== 2'b00) begin n_err++; $display("FAIL 4x4_errors: got %b%b expected 00", err_partial, err_overflow); end
  endtask

  task automatic test_single_word();
    logic [WORD_W-1:0] w = 20'hABCDE;
    got_q.delete(); wif.word_ready = 1'b0;
    send_bits(w, 0, WORD_W - 1);
    n_vec++; if (wif.word_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b expected 0", wif.word_valid); end
    send_bits(w, WORD_W - 1, 1);
    n_vec++; if (wif.word_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_latency: got %b expected 1", wif.word_valid); end
    n_vec++; if (wif.word_data !== w) begin n_err++; $display("FAIL single_word_data: got %h expected %h", wif.word_data, w); end
    end_frame();
    n_vec++; if (wif.word_data !== w || wif.word_valid !== 1'b1) begin n_err++; $display("FAIL single_hold_stable: got %b/%h expected 1/%h", wif.word_valid, wif.word_data, w); end
    n_vec++; if (frame_words !== CNT_W'(1)) begin n_err++; $display("FAIL single_frame_words: got %0d expected 1", frame_words); end
    wif.word_ready = 1'b1;
    tick();
    n_vec++; if (wif.word_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_empty: got %b expected 0", wif.word_valid); end
    n_vec++; if (got_q.size() !== 1 || got_q[0] !== w) begin n_err++; $display("FAIL single_popped: got size %0d expected 1 word %h", got_q.size(), w); end
  endtask

  task automatic test_overflow();
    logic [WORD_W-1:0] w[10];
    got_q.delete(); wif.word_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      w[k] = WORD_W'($urandom);
      send_word(w[k]);
      if (k == DEPTH - 1) begin
        n_vec++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_after_full: got %b expected 0", err_overflow); end
      end
      if (k == DEPTH) begin
        n_vec++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_after_9th: got %b expected 1", err_overflow); end
      end
    end
    end_frame();
    n_vec++; if (frame_words !== CNT_W'(10)) begin n_err++; $display("FAIL ovf_frame_words: got %0d expected 10", frame_words); end
    drain();
    n_vec++; if (got_q.size() !== DEPTH) begin n_err++; $display("FAIL ovf_kept_count: got %0d expected %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== w[i]) begin n_err++; $display("FAIL ovf_word[%0d]: got %h expected %h", i, got_q[i], w[i]); end
    end
  endtask

  task automatic test_partial();
    logic [WORD_W-1:0] w = WORD_W'($urandom);
    got_q.delete(); wif.word_ready = 1'b1;
    send_word(w);
    send_bits(WORD_W'($urandom), 0, 7);
    end_frame();
    n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL partial_frame_done: got %b expected 1", frame_done); end
    n_vec++; if (frame_words !== CNT_W'(1)) begin n_err++; $display("FAIL partial_frame_words: got %0d expected 1", frame_words); end
    n_vec++; if (err_partial !== 1'b1 || err_overflow !== 1'b1) begin n_err++; $display("FAIL partial_errs_set: got %b%b expected 11", err_partial, err_overflow); end
    drain();
    n_vec++; if (got_q.size() !== 1 || got_q[0] !== w) begin n_err++; $display("FAIL partial_stored: got size %0d expected 1 word %h", got_q.size(), w); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_vec++; if ({err_partial, err_overflow} !== 2'b00) begin n_err++; $display("FAIL partial_clr: got %b%b expected 00", err_partial, err_overflow); end
    // clr_err coinciding with a partial frame end must lose to the set.
    send_bits(WORD_W'($urandom), 0, 5);
    clr_err = 1'b1; end_frame(); clr_err = 1'b0;
    n_vec++; if (err_partial !== 1'b1) begin n_err++; $display("FAIL partial_set_wins: got %b expected 1", err_partial); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1 = 0, s2 = 0;
    logic [WORD_W-1:0] w;
    got_q.delete(); done_cnt = 0; wif.word_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin w = WORD_W'($urandom); s1 += 32'(w); send_word(w); end
    out_valid = 1'b0; tick();
    n_vec++; if (frame_done !== 1'b1 || frame_words !== CNT_W'(2)) begin n_err++; $display("FAIL b2b_first: got %b/%0d expected 1/2", frame_done, frame_words); end
`ifdef TMIP_COLLECT_SUM_EN
    n_vec++; if (frame_sum !== s1) begin n_err++; $display("FAIL b2b_sum1: got %0d expected %0d", frame_sum, s1); end
`endif
    for (int k = 0; k < 3; k++) begin w = WORD_W'($urandom); s2 += 32'(w); send_word(w); end
    n_vec++; if (frame_words !== CNT_W'(2)) begin n_err++; $display("FAIL b2b_hold: got %0d expected 2", frame_words); end
    end_frame();
    n_vec++; if (frame_done !== 1'b1 || frame_words !== CNT_W'(3)) begin n_err++; $display("FAIL b2b_second: got %b/%0d expected 1/3", frame_done, frame_words); end
`ifdef TMIP_COLLECT_SUM_EN
    n_vec++; if (frame_sum !== s2) begin n_err++; $display("FAIL b2b_sum2: got %0d expected %0d", frame_sum, s2); end
`endif
    drain();
    n_vec++; if (done_cnt !== 2 || got_q.size() !== 5) begin n_err++; $display("FAIL b2b_totals: got %0d pulses %0d words expected 2 pulses 5 words", done_cnt, got_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [WORD_W-1:0] w;
    got_q.delete(); wif.word_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_word(WORD_W'($urandom));
    send_bits(WORD_W'($urandom), 0, 7);
    n_vec++; if (wif.word_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_queued: got %b expected 1", wif.word_valid); end
    #2 rst_n = 1'b0; out_valid = 1'b0; done_cnt = 0;
    #1 test_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    n_vec++; if (done_cnt !== 0 || wif.word_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after: got %0d pulses valid %b expected 0/0", done_cnt, wif.word_valid); end
    got_q.delete(); wif.word_ready = 1'b1;
    w = WORD_W'($urandom);
    send_word(w);
    end_frame();
    n_vec++; if (frame_words !== CNT_W'(1) || err_partial !== 1'b0) begin n_err++; $display("FAIL rstmid_frame: got %0d/%b expected 1/0", frame_words, err_partial); end
    drain();
    n_vec++; if (got_q.size() !== 1 || got_q[0] !== w) begin n_err++; $display("FAIL rstmid_word: got size %0d expected 1 word %h", got_q.size(), w); end
  endtask

  task automatic test_random_frames();
    logic [WORD_W-1:0] exp_q[$];
    logic [31:0] s;
    int nw, part;
    for (int f = 0; f < 6; f++) begin
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      got_q.delete(); exp_q.delete(); s = 0;
      nw = $urandom_range(1, 10);
      part = $urandom_range(0, WORD_W - 1);
      rand_ready = 1'b1;
      for (int k = 0; k < nw; k++) begin
        exp_q.push_back(WORD_W'($urandom));
        s += 32'(exp_q[k]);
        send_word(exp_q[k]);
      end
      if (part != 0) send_bits(WORD_W'($urandom), 0, part);
      rand_ready = 1'b0;
      end_frame();
      n_vec++; if (frame_done !== 1'b1 || frame_words !== CNT_W'(nw)) begin n_err++; $display("FAIL rand%0d_frame: got %b/%0d expected 1/%0d", f, frame_done, frame_words, nw); end
      n_vec++; if (err_partial !== (part != 0)) begin n_err++; $display("FAIL rand%0d_partial: got %b expected %b", f, err_partial, part != 0); end
`ifdef TMIP_COLLECT_SUM_EN
      n_vec++; if (frame_sum !== s) begin n_err++; $display("FAIL rand%0d_sum: got %0d expected %0d", f, frame_sum, s); end
`endif
      drain();
      n_vec++; if (got_q.size() !== nw) begin n_err++; $display("FAIL rand%0d_count: got %0d expected %0d", f, got_q.size(), nw); end
      for (int i = 0; i < nw && i < got_q.size(); i++) begin
        n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_word[%0d]: got %h expected %h", f, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    wif.word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 test_reset();
    rst_n = 1'b1;
    tick();
    test_frame_4x4();
    test_single_word();
    test_overflow();
    test_partial();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
